// File: rtl/floor.sv
// Two-stage pipelined IEEE-754 single-precision floor (round toward -inf).
// Stage 1 classifies the operand and builds the fraction mask; stage 2 forms the result.
module floor (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x1,
   output logic [31:0] y
);

   localparam int unsigned W  = 32;
   localparam int unsigned EW = 8;
   localparam int unsigned MW = 23;

   typedef enum logic [1:0] {
      C_PASS,  // inf, NaN, or already integral
      C_ZERO,  // zero or denormal, flushed to signed zero
      C_SUB,   // 0 < |x| < 1
      C_FRAC   // has fraction bits inside the mantissa
   } kind_t;

   logic [W-1:0]  op_q;
   logic [MW-1:0] mask_q;
   logic          inexact_q;
   kind_t         kind_q;

   logic [EW-1:0] e_c;
   logic [4:0]    n_c;
   logic [MW-1:0] mask_c;
   logic          inexact_c;
   kind_t         kind_c;

   logic [W-2:0]  t_c;
   logic [W-1:0]  y_c;

   // Stage 1: classification and fractional-bit mask
   always_comb begin
      e_c       = x1[30:23];
      n_c       = 5'(8'd150 - e_c);
      mask_c    = '0;
      kind_c    = C_PASS;
      if (e_c == 8'd0) begin
         kind_c = C_ZERO;
      end else if (e_c < 8'd127) begin
         kind_c = C_SUB;
      end else if (e_c < 8'd150) begin
         kind_c = C_FRAC;
         mask_c = ~({MW{1'b1}} << n_c);
      end
      inexact_c = |(x1[MW-1:0] & mask_c);
   end

   // Stage 2: truncate, and bump negative inexact values by one unit;
   // the add spans {e,m} so a mantissa carry rolls into the exponent.
   always_comb begin
      t_c = op_q[W-2:0] & ~{8'h00, mask_q};
      if (op_q[W-1] && inexact_q) begin
         t_c = t_c + {8'h00, mask_q} + 31'd1;
      end
      y_c = op_q;
      case (kind_q)
         C_PASS:  y_c = op_q;
         C_ZERO:  y_c = {op_q[W-1], 31'd0};
         C_SUB:   y_c = op_q[W-1] ? 32'hBF80_0000 : 32'h0000_0000;
         C_FRAC:  y_c = {op_q[W-1], t_c};
         default: y_c = op_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= '0;
         mask_q    <= '0;
         inexact_q <= 1'b0;
         kind_q    <= C_PASS;
         y         <= '0;
      end else begin
         op_q      <= x1;
         mask_q    <= mask_c;
         inexact_q <= inexact_c;
         kind_q    <= kind_c;
         y         <= y_c;
      end
   end

endmodule

// File: tb/tb_floor.sv
// Scoreboard bench for floor: driver queues reference results, monitor pops and compares.
module tb_floor;

   logic        clk;
   logic        rst;
   logic [31:0] x1;
   logic [31:0] y;

   typedef struct {
      logic [31:0] x;
      logic [31:0] exp;
      int          due;
   } item_t;

   item_t sb[$];
   int    cyc;
   int    checks;
   int    errors;
   bit    zero_win;

   floor dut (
      .clk (clk),
      .rst (rst),
      .x1  (x1),
      .y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: integer value of the operand, floored, then re-encoded.
   function automatic logic [31:0] ref_floor(input logic [31:0] a);
      logic        s;
      int unsigned e;
      int unsigned sig;
      int unsigned n;
      int unsigned q;
      int unsigned p;
      logic [31:0] mant;
      s = a[31];
      e = int'(a[30:23]);
      if (e >= 150) return a;
      if (e == 0) return {s, 31'd0};
      if (e < 127) return s ? 32'hBF80_0000 : 32'h0000_0000;
      sig = {9'd1, a[22:0]};
      n   = 150 - e;
      q   = sig >> n;
      if (s && (sig - (q << n)) != 0) q = q + 1;
      p = 0;
      for (int i = 0; i < 32; i++) if (q[i]) p = i;
      mant = q << (23 - p);
      return {s, 8'(127 + p), mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(120, 152));
      return r;
   endfunction

   task automatic drive(input logic [31:0] v);
      item_t it;
      @(negedge clk);
      #1;
      rst = 1'b0;
      x1  = v;
      it.x   = v;
      it.exp = ref_floor(v);
      it.due = cyc + 2;
      sb.push_back(it);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      zero_win = 1'b1;
      repeat (cycles - 1) @(negedge clk);
   endtask

   // Monitor: compare y against the scoreboard entry due this cycle
   always @(negedge clk) begin
      item_t it;
      if (rst) begin
         checks = checks + 1;
         if (y !== 32'h0) begin
            errors = errors + 1;
            $display("FAIL reset_zero y=%h expected=00000000", y);
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         it = sb.pop_front();
         zero_win = 1'b0;
         checks = checks + 1;
         if (it.due < cyc) begin
            errors = errors + 1;
            $display("FAIL late_result x1=%h due=%0d now=%0d", it.x, it.due, cyc);
         end else if (y !== it.exp) begin
            errors = errors + 1;
            $display("FAIL floor x1=%h y=%h expected=%h", it.x, y, it.exp);
         end
      end else if (zero_win) begin
         checks = checks + 1;
         if (y !== 32'h0) begin
            errors = errors + 1;
            $display("FAIL idle_zero y=%h expected=00000000", y);
         end
      end
   end

   logic [31:0] directed [16] = '{
      32'h4020_0000, 32'hC020_0000, 32'h4040_0000, 32'hC040_0000,
      32'h3F40_0000, 32'hBF40_0000, 32'h8000_0000, 32'h8000_0001,
      32'hBFC0_0000, 32'hCAFF_FFFF, 32'h5015_02F9, 32'h7F80_0000,
      32'h7FC0_0001, 32'h4B00_0001, 32'h0000_0000, 32'hFF80_0000
   };

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      zero_win = 1'b1;
      rst      = 1'b1;
      x1       = 32'h4020_0000;
      repeat (2) @(negedge clk);

      foreach (directed[i]) drive(directed[i]);
      repeat (10) drive(rand_op());
      repeat (300) drive(rand_op());

      // Mid-stream reset: operands in flight must never appear
      repeat (5) drive(rand_op());
      do_reset(2);
      repeat (3) @(negedge clk);
      x1 = 32'hC020_0000;
      repeat (2) @(negedge clk);
      drive(32'hC020_0000);
      repeat (20) drive(rand_op());

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb.size() > 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/floor.md
Name: floor

Overview:
- Pipelined IEEE-754 single-precision floor unit for the CPU's FPU datapath.
- Takes a 32-bit float and returns the largest integral float not greater than it, i.e. it rounds toward −∞.
- Fully pipelined: it accepts one operand every clock, has a fixed latency of 2 clocks, and has no handshake.

Parameters:
- None. Latency is fixed at 2 register stages.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- x1  input  32  operand, IEEE-754 single.
- y  output  32  floor(x1), IEEE-754 single; registered.

Behaviour:
- Field split: s = x1[31], e = x1[30:23], m = x1[22:0].
- Pipeline timing:
  - x1 is sampled on edge N.
  - The corresponding y is driven from edge N+1 and is valid until edge N+2, i.e. it is visible when sampled at edge N+2.
  - Each edge advances every stage unconditionally. No stall, no valid bit.
- Stage 1 (registered at the first edge) classifies the operand and holds:
  - the operand;
  - a fractional-bit mask;
  - an "inexact" flag (any masked bit of m set);
  - a case code.
- Stage 2 (registered at the second edge) forms y.
- Case rules:
  - e == 255 (±inf, NaN): y = x1 unchanged. NaN payload and sign are preserved.
  - e >= 150 (|x| >= 2^23, already integral): y = x1 unchanged.
  - e == 0 (±0 and denormals; denormals are flushed): y = {s, 31'b0}.
  - 1 <= e <= 126 (0 < |x| < 1):
    - s = 0 → y = 0x00000000.
    - s = 1 → y = 0xBF800000 (−1.0).
  - 127 <= e <= 149:
    - n = 150 − e fraction bits (1..23); mask = (1<<n) − 1.
    - Truncate: t = x1[30:0] with the low n bits cleared.
    - If s = 1 and the inexact flag is set: t = t + (1<<n). Apply the add on the full 31-bit {e,m} field so that a mantissa carry increments the exponent (e.g. −1.5 → −2.0). The result cannot overflow to inf, because the maximum is 2^23.
    - y = {s, t}.
- Positive operands give truncation toward zero. Negative non-integers round away from zero.
- Sign is preserved in every case; −0.0 stays −0.0.
- Reset:
  - While rst = 1, all pipeline registers clear asynchronously and y = 0x00000000.
  - Reset applied mid-stream discards all in-flight operands.
  - After rst deasserts, the first valid y appears 2 edges after the first sampled operand.
  - Until then, y = 0x00000000.
- No exceptions or flags are produced.
- Purely combinational logic between registers; no multicycle paths.

Test Plan:
- Reset: assert rst for 2 cycles with x1 = 0x40200000 → y = 0x00000000 throughout. Deassert; y = 0x40000000 two edges after first sample.
- Basic fractional values:
  - 2.5 (0x40200000) → 0x40000000 (2.0).
  - −2.5 (0xC0200000) → 0xC0400000 (−3.0).
  - 3.0 (0x40400000) → 0x40400000.
  - −3.0 (0xC0400000) → 0xC0400000.
- Sub-unity and zero:
  - 0.75 (0x3F400000) → 0x00000000.
  - −0.75 (0xBF400000) → 0xBF800000.
  - 0x80000000 → 0x80000000.
  - Denormal 0x80000001 → 0x80000000.
- Exponent carry: −1.5 (0xBFC00000) → 0xC0000000. −8388607.5 (0xCAFFFFFF) → 0xCB000000 (−8388608.0).
- Pass-through:
  - 1e10 (0x501502F9) → unchanged.
  - +inf (0x7F800000) → unchanged.
  - NaN (0x7FC00001) → unchanged.
  - 0x4B000001 → unchanged.
- Throughput: apply 10 random operands on consecutive edges → each y matches the reference floor 2 edges after its input, with no bubbles. Then assert rst mid-stream → y = 0 immediately and the stale results are never output.
